// File: rtl/nbody_step_seq.sv
// Pair-schedule sequencer for the n-body accelerator: issues all (i,j) pairs for the
// velocity phase, then each body once for the position phase, over several time steps.
module nbody_step_seq #(
    parameter int BODIES    = 512,
    parameter int BODY_AW   = $clog2(BODIES),
    parameter int ACC_LAT   = 78,
    parameter int POS_LAT   = 20,
    parameter int STEP_W    = 16,
    parameter int SKIP_SELF = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [BODY_AW:0]   num_bodies,
    input  logic [STEP_W-1:0]  num_steps,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [1:0]         phase,
    output logic               first_step,
    output logic               pair_valid,
    output logic [BODY_AW-1:0] pair_i,
    output logic [BODY_AW-1:0] pair_j,
    output logic               pair_last,
    output logic               acc_wr_valid,
    output logic [BODY_AW-1:0] acc_wr_addr,
    output logic               pos_rd_valid,
    output logic [BODY_AW-1:0] pos_rd_addr,
    output logic               pos_wr_valid,
    output logic [BODY_AW-1:0] pos_wr_addr,
    output logic [STEP_W-1:0]  step_count
);

    localparam int NW      = BODY_AW + 1;
    localparam int DLY_MAX = (ACC_LAT > POS_LAT) ? ACC_LAT : POS_LAT;
    localparam int CW      = $clog2(DLY_MAX + 1);
    localparam logic [BODY_AW-1:0] J_FIRST = (SKIP_SELF != 0) ? BODY_AW'(1) : '0;

    typedef enum logic [2:0] {
        S_IDLE, S_ACC_ISSUE, S_ACC_DRAIN, S_POS_ISSUE, S_POS_DRAIN, S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic [NW-1:0]      nb;
    logic [STEP_W-1:0]  ns;
    logic [BODY_AW-1:0] i_cnt, j_cnt, p_cnt, j_inc, j_nxt;
    logic [CW-1:0]      dly_cnt;
    logic [NW-1:0]      nb_m1, last_j;
    logic               pair_last_c, last_i, pos_last;
    logic               acc_drain_end, pos_drain_end, last_step, bad_nb;

    logic [ACC_LAT-1:0]              acc_vld_dly;
    logic [ACC_LAT-1:0][BODY_AW-1:0] acc_addr_dly;
    logic [POS_LAT-1:0]              pos_vld_dly;
    logic [POS_LAT-1:0][BODY_AW-1:0] pos_addr_dly;

    // Comparisons run at BODY_AW+1 bits so nb == BODIES does not overflow.
    always_comb begin
        nb_m1         = nb - NW'(1);
        last_j        = (SKIP_SELF != 0 && {1'b0, i_cnt} == nb_m1) ? nb - NW'(2) : nb_m1;
        pair_last_c   = ({1'b0, j_cnt} == last_j);
        last_i        = ({1'b0, i_cnt} == nb_m1);
        pos_last      = ({1'b0, p_cnt} == nb_m1);
        acc_drain_end = (dly_cnt == CW'(ACC_LAT - 1));
        pos_drain_end = (dly_cnt == CW'(POS_LAT - 1));
        last_step     = (step_count == ns - STEP_W'(1));
        bad_nb        = (num_bodies < NW'(2)) || (num_bodies > NW'(BODIES));
        j_inc         = j_cnt + BODY_AW'(1);
        j_nxt         = (SKIP_SELF != 0 && j_inc == i_cnt) ? j_inc + BODY_AW'(1) : j_inc;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start && !bad_nb && num_steps != '0) state_nxt = S_ACC_ISSUE;
            S_ACC_ISSUE: if (pair_last_c && last_i) state_nxt = S_ACC_DRAIN;
            S_ACC_DRAIN: if (acc_drain_end) state_nxt = S_POS_ISSUE;
            S_POS_ISSUE: if (pos_last) state_nxt = S_POS_DRAIN;
            S_POS_DRAIN: if (pos_drain_end) state_nxt = last_step ? S_FINISH : S_ACC_ISSUE;
            S_FINISH:    state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nb         <= '0;
            ns         <= '0;
            i_cnt      <= '0;
            j_cnt      <= '0;
            p_cnt      <= '0;
            dly_cnt    <= '0;
            step_count <= '0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else if (!abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (bad_nb) begin
                            cfg_err <= 1'b1;
                        end else begin
                            nb         <= num_bodies;
                            ns         <= num_steps;
                            cfg_err    <= 1'b0;
                            step_count <= '0;
                            done       <= (num_steps == '0);
                            i_cnt      <= '0;
                            j_cnt      <= J_FIRST;
                            p_cnt      <= '0;
                            dly_cnt    <= '0;
                        end
                    end
                end
                S_ACC_ISSUE: begin
                    if (pair_last_c) begin
                        if (last_i) begin
                            i_cnt <= '0;
                            j_cnt <= J_FIRST;
                        end else begin
                            i_cnt <= i_cnt + BODY_AW'(1);
                            j_cnt <= '0;
                        end
                    end else begin
                        j_cnt <= j_nxt;
                    end
                end
                S_ACC_DRAIN: dly_cnt <= acc_drain_end ? '0 : dly_cnt + CW'(1);
                S_POS_ISSUE: p_cnt <= pos_last ? '0 : p_cnt + BODY_AW'(1);
                S_POS_DRAIN: begin
                    dly_cnt <= pos_drain_end ? '0 : dly_cnt + CW'(1);
                    if (pos_drain_end && !last_step) step_count <= step_count + STEP_W'(1);
                end
                S_FINISH: done <= 1'b1;
                default: ;
            endcase
        end
    end

    // Latency-matching delay lines: free-running, only abort drops the pending valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_vld_dly  <= '0;
            acc_addr_dly <= '0;
            pos_vld_dly  <= '0;
            pos_addr_dly <= '0;
        end else begin
            acc_vld_dly[0]  <= pair_last && !abort;
            acc_addr_dly[0] <= i_cnt;
            for (int k = 1; k < ACC_LAT; k++) begin
                acc_vld_dly[k]  <= acc_vld_dly[k-1] && !abort;
                acc_addr_dly[k] <= acc_addr_dly[k-1];
            end
            pos_vld_dly[0]  <= pos_rd_valid && !abort;
            pos_addr_dly[0] <= p_cnt;
            for (int k = 1; k < POS_LAT; k++) begin
                pos_vld_dly[k]  <= pos_vld_dly[k-1] && !abort;
                pos_addr_dly[k] <= pos_addr_dly[k-1];
            end
        end
    end

    always_comb begin
        phase = 2'd0;
        case (state)
            S_ACC_ISSUE, S_ACC_DRAIN: phase = 2'd1;
            S_POS_ISSUE, S_POS_DRAIN: phase = 2'd2;
            default: ;
        endcase
    end

    assign busy         = (state != S_IDLE);
    assign first_step   = busy && (step_count == '0);
    assign pair_valid   = (state == S_ACC_ISSUE);
    assign pair_i       = i_cnt;
    assign pair_j       = j_cnt;
    assign pair_last    = pair_valid && pair_last_c;
    assign pos_rd_valid = (state == S_POS_ISSUE);
    assign pos_rd_addr  = p_cnt;
    assign acc_wr_valid = acc_vld_dly[ACC_LAT-1];
    assign acc_wr_addr  = acc_addr_dly[ACC_LAT-1];
    assign pos_wr_valid = pos_vld_dly[POS_LAT-1];
    assign pos_wr_addr  = pos_addr_dly[POS_LAT-1];

endmodule
